// File: rtl/keccak_ctrl_pkg.sv
// Shared definitions for the Keccak l.cust5 front end: opcodes, modes, states, rate lookups.
package keccak_ctrl_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned LIMM_W = 6;
    localparam int unsigned WCNT_W = 6;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned TB_W   = 3;

    localparam logic [OP_W-1:0] OP_HEAD  = 5'b00100;
    localparam logic [OP_W-1:0] OP_DATA  = 5'b00010;
    localparam logic [OP_W-1:0] OP_TAIL  = 5'b00001;
    localparam logic [OP_W-1:0] OP_STORE = 5'b01000;

    typedef enum logic [1:0] {
        MODE_224 = 2'b00,
        MODE_256 = 2'b01,
        MODE_384 = 2'b10,
        MODE_512 = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_ISSUE,
        ST_WAIT_DIG,
        ST_DONE
    } state_e;

    // 32-bit words per rate block
    function automatic logic [WCNT_W-1:0] wpb_of(input mode_e m);
        case (m)
            MODE_224: return WCNT_W'(36);
            MODE_256: return WCNT_W'(34);
            MODE_384: return WCNT_W'(26);
            default:  return WCNT_W'(18);
        endcase
    endfunction

    // 32-bit words of digest kept for readback
    function automatic logic [4:0] dig_words_of(input mode_e m);
        case (m)
            MODE_224: return 5'd7;
            MODE_256: return 5'd8;
            MODE_384: return 5'd12;
            default:  return 5'd16;
        endcase
    endfunction

    // Tail byte count saturates at a full word
    function automatic logic [TB_W-1:0] tail_bytes(input logic [TB_W-1:0] n);
        return (n > TB_W'(4)) ? TB_W'(4) : n;
    endfunction

endpackage

// File: rtl/keccak_cust5_ctrl_if.sv
// CPU custom-instruction and permutation-core signals of the Keccak l.cust5 front end.
interface keccak_cust5_ctrl_if #(
    parameter int unsigned DW       = 32,
    parameter int unsigned RATE_MAX = 1152,
    parameter int unsigned DIG_MAX  = 512
);
    logic                op_valid;
    logic [4:0]          cust5_op;
    logic [5:0]          cust5_limm;
    logic [DW-1:0]       operand_a;
    logic                stall;
    logic [DW-1:0]       dataout;
    logic                blk_valid;
    logic                blk_ready;
    logic [RATE_MAX-1:0] blk_data;
    logic                blk_first;
    logic                blk_last;
    logic                dig_valid;
    logic [DIG_MAX-1:0]  dig_data;
    logic                busy;

    modport master (
        output op_valid, cust5_op, cust5_limm, operand_a, blk_ready, dig_valid, dig_data,
        input  stall, dataout, blk_valid, blk_data, blk_first, blk_last, busy
    );

    modport slave (
        input  op_valid, cust5_op, cust5_limm, operand_a, blk_ready, dig_valid, dig_data,
        output stall, dataout, blk_valid, blk_data, blk_first, blk_last, busy
    );
endinterface

// File: rtl/keccak_pad_buf.sv
// Rate block buffer: word writes, byte-masked tail write, SHA-3 pad insertion.
module keccak_pad_buf
    import keccak_ctrl_pkg::*;
#(
    parameter int unsigned RATE_MAX = 1152
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                wr_i,
    input  logic                tail_i,
    input  logic                pad_i,
    input  logic [WCNT_W-1:0]   idx_i,
    input  logic [TB_W-1:0]     nbytes_i,
    input  logic [WCNT_W-1:0]   wpb_i,
    input  logic [WORD_W-1:0]   data_i,
    output logic [RATE_MAX-1:0] blk_o
);
    localparam int unsigned NB = RATE_MAX / 8;

    logic [RATE_MAX-1:0] blk_q, blk_d;

    // Clear applies first so a pad block can be built in the same cycle
    always_comb begin
        blk_d = clr_i ? '0 : blk_q;
        for (int unsigned b = 0; b < NB; b++) begin
            if ((wr_i || tail_i) && (b / 4 == 32'(idx_i)) &&
                (wr_i || (b % 4 < 32'(nbytes_i)))) begin
                blk_d[RATE_MAX-1-8*b -: 8] = data_i[WORD_W-1-8*(b%4) -: 8];
            end
            if (tail_i && pad_i && (b == 32'(idx_i) * 4 + 32'(nbytes_i))) begin
                blk_d[RATE_MAX-1-8*b -: 8] = blk_d[RATE_MAX-1-8*b -: 8] | 8'h06;
            end
            if (tail_i && pad_i && (b == 32'(wpb_i) * 4 - 1)) begin
                blk_d[RATE_MAX-1-8*b -: 8] = blk_d[RATE_MAX-1-8*b -: 8] | 8'h80;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blk_q <= '0;
        else      blk_q <= blk_d;
    end

    assign blk_o = blk_q;
endmodule

// File: rtl/keccak_cust5_ctrl.sv
// l.cust5 front end for the Keccak core: packs CPU words into padded rate blocks, reads back digest.
// Optional KECCAK_CTRL_ERR_EN adds a sticky err output for misuse of the instruction stream.
module keccak_cust5_ctrl
    import keccak_ctrl_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned RATE_MAX = 1152,
    parameter int unsigned DIG_MAX  = 512
) (
    input  logic clk,
    input  logic rst,
`ifdef KECCAK_CTRL_ERR_EN
    output logic err,
`endif
    keccak_cust5_ctrl_if.slave bus
);
    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               pad_pend_q, pad_pend_d;
    logic               blk_valid_q, blk_valid_d;
    logic               busy_q, busy_d;
    logic [DW-1:0]      dataout_q, dataout_d;
    logic [DIG_MAX-1:0] dig_q, dig_d;

    logic               pb_clr, pb_wr, pb_tail, pb_pad;
    logic [WCNT_W-1:0]  pb_idx;
    logic [TB_W-1:0]    pb_nb;
    logic [WCNT_W-1:0]  wpb;
    logic               is_head, is_data, is_tail, is_store, stall_c, tail_exact;
    logic               unused_limm;

    assign is_head  = bus.op_valid && (bus.cust5_op == OP_HEAD);
    assign is_data  = bus.op_valid && (bus.cust5_op == OP_DATA);
    assign is_tail  = bus.op_valid && (bus.cust5_op == OP_TAIL);
    assign is_store = bus.op_valid && (bus.cust5_op == OP_STORE);
    assign wpb      = wpb_of(mode_q);
    assign unused_limm = ^bus.cust5_limm[5:4];

    assign stall_c = bus.op_valid &&
                     (((state_q == ST_ISSUE) && (is_head || is_data || is_tail)) ||
                      (state_q == ST_WAIT_DIG));

    // A 4-byte tail into the last word leaves no room for padding in this block
    assign tail_exact = (tail_bytes(bus.cust5_limm[2:0]) == TB_W'(4)) &&
                        (wcnt_q == wpb - WCNT_W'(1));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wcnt_d     = wcnt_q;
        first_d    = first_q;
        last_d     = last_q;
        pad_pend_d = pad_pend_q;
        dataout_d  = dataout_q;
        dig_d      = dig_q;
        pb_clr     = 1'b0;
        pb_wr      = 1'b0;
        pb_tail    = 1'b0;
        pb_pad     = 1'b0;
        pb_idx     = wcnt_q;
        pb_nb      = tail_bytes(bus.cust5_limm[2:0]);

        case (state_q)
            ST_IDLE, ST_ABSORB, ST_DONE: begin
                if (is_head) begin
                    pb_clr     = 1'b1;
                    wcnt_d     = '0;
                    mode_d     = mode_e'(bus.cust5_limm[1:0]);
                    first_d    = 1'b1;
                    last_d     = 1'b0;
                    pad_pend_d = 1'b0;
                    state_d    = ST_ABSORB;
                end else if ((state_q == ST_ABSORB) && is_data) begin
                    pb_wr  = 1'b1;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (wcnt_d == wpb) begin
                        last_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end else if ((state_q == ST_ABSORB) && is_tail) begin
                    pb_tail    = 1'b1;
                    pb_pad     = !tail_exact;
                    last_d     = !tail_exact;
                    pad_pend_d = tail_exact;
                    state_d    = ST_ISSUE;
                end else if ((state_q == ST_DONE) && is_store) begin
                    dataout_d = dig_q[DIG_MAX-1-DW*32'(bus.cust5_limm[3:0]) -: DW];
                end
            end
            ST_ISSUE: begin
                if (bus.blk_ready) begin
                    first_d = 1'b0;
                    wcnt_d  = '0;
                    pb_clr  = 1'b1;
                    if (pad_pend_q) begin
                        // Rebuild the buffer as the all-pad block and keep offering it
                        pb_tail    = 1'b1;
                        pb_pad     = 1'b1;
                        pb_idx     = '0;
                        pb_nb      = '0;
                        pad_pend_d = 1'b0;
                        last_d     = 1'b1;
                    end else if (last_q) begin
                        state_d = ST_WAIT_DIG;
                    end else begin
                        state_d = ST_ABSORB;
                    end
                end
            end
            ST_WAIT_DIG: begin
                if (bus.dig_valid) begin
                    dig_d = '0;
                    for (int unsigned w = 0; w < DIG_MAX / DW; w++) begin
                        if (w < 32'(dig_words_of(mode_q))) begin
                            dig_d[DIG_MAX-1-DW*w -: DW] = bus.dig_data[DIG_MAX-1-DW*w -: DW];
                        end
                    end
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        blk_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_224;
            wcnt_q      <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            pad_pend_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dataout_q   <= '0;
            dig_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wcnt_q      <= wcnt_d;
            first_q     <= first_d;
            last_q      <= last_d;
            pad_pend_q  <= pad_pend_d;
            blk_valid_q <= blk_valid_d;
            busy_q      <= busy_d;
            dataout_q   <= dataout_d;
            dig_q       <= dig_d;
        end
    end

    keccak_pad_buf #(.RATE_MAX(RATE_MAX)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (pb_clr),
        .wr_i     (pb_wr),
        .tail_i   (pb_tail),
        .pad_i    (pb_pad),
        .idx_i    (pb_idx),
        .nbytes_i (pb_nb),
        .wpb_i    (wpb),
        .data_i   (WORD_W'(bus.operand_a)),
        .blk_o    (bus.blk_data)
    );

    assign bus.stall     = stall_c;
    assign bus.dataout   = dataout_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_first = first_q;
    assign bus.blk_last  = last_q;
    assign bus.busy      = busy_q;

`ifdef KECCAK_CTRL_ERR_EN
    logic err_q, err_d;

    // Sticky misuse flag; only ops that are not stalled are judged
    always_comb begin
        err_d = err_q;
        if (bus.op_valid && !stall_c) begin
            if (is_head)                                             err_d = 1'b0;
            else if (!(is_data || is_tail || is_store))              err_d = 1'b1;
            else if ((is_data || is_tail) && state_q != ST_ABSORB)   err_d = 1'b1;
            else if (is_store && state_q != ST_DONE)                 err_d = 1'b1;
            else if (is_tail && bus.cust5_limm[2:0] > TB_W'(4))      err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_keccak_cust5_ctrl.sv
// Directed bench for keccak_cust5_ctrl: block packing, padding, stall, digest readback, reset.
module tb_keccak_cust5_ctrl;
    import keccak_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keccak_cust5_ctrl_if bus ();
`ifdef KECCAK_CTRL_ERR_EN
    logic err;
`endif

    keccak_cust5_ctrl dut (
        .clk (clk),
        .rst (rst),
`ifdef KECCAK_CTRL_ERR_EN
        .err (err),
`endif
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0]   eb [144];
    logic [511:0] dig_vec;
    string msg = "The quick brown fox jumps over the lazy dog.";

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [4:0] code, input logic [5:0] limm, input logic [31:0] a);
        bus.op_valid   = 1'b1;
        bus.cust5_op   = code;
        bus.cust5_limm = limm;
        bus.operand_a  = a;
        cyc();
        bus.op_valid   = 1'b0;
    endtask

    task automatic eb_clr();
        foreach (eb[k]) eb[k] = 8'h00;
    endtask

    task automatic eb_word(input int i, input logic [31:0] w);
        {eb[4*i], eb[4*i+1], eb[4*i+2], eb[4*i+3]} = w;
    endtask

    task automatic chk_blk(input string tag, input logic first, input logic last);
        chk({tag, "_vld"},   64'(bus.blk_valid), 64'd1);
        chk({tag, "_first"}, 64'(bus.blk_first), 64'(first));
        chk({tag, "_last"},  64'(bus.blk_last),  64'(last));
        for (int i = 0; i < 36; i++) begin
            chk($sformatf("%s_w%0d", tag, i), 64'(bus.blk_data[1151-32*i -: 32]),
                64'({eb[4*i], eb[4*i+1], eb[4*i+2], eb[4*i+3]}));
        end
    endtask

    task automatic hs();
        bus.blk_ready = 1'b1;
        cyc();
        bus.blk_ready = 1'b0;
    endtask

    task automatic give_dig(input logic [511:0] d);
        bus.dig_data  = d;
        bus.dig_valid = 1'b1;
        cyc();
        bus.dig_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid = 1'b0; bus.cust5_op = '0; bus.cust5_limm = '0; bus.operand_a = '0;
        bus.blk_ready = 1'b0; bus.dig_valid = 1'b0; bus.dig_data = '0;
        for (int w = 0; w < 16; w++) dig_vec[511-32*w -: 32] = 32'h1e83d5b4 + 32'(w) * 32'h01010101;

        rst = 1'b0;
        #12;
        chk("rst_vld",   64'(bus.blk_valid), 64'd0);
        chk("rst_busy",  64'(bus.busy),      64'd0);
        chk("rst_first", 64'(bus.blk_first), 64'd0);
        chk("rst_last",  64'(bus.blk_last),  64'd0);
        chk("rst_dout",  64'(bus.dataout),   64'd0);
        chk("rst_blk",   64'(|bus.blk_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc();

        // DATA in IDLE: ignored without stalling
        bus.op_valid = 1'b1; bus.cust5_op = OP_DATA; bus.operand_a = 32'h12345678;
        #1;
        chk("idle_stall", 64'(bus.stall), 64'd0);
        cyc();
        bus.op_valid = 1'b0;
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // SHA3-512, 44-byte message, empty tail
        op(OP_HEAD, 6'b000011, 32'h0);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 11; i++) op(OP_DATA, 6'd0, {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
        op(OP_TAIL, 6'd0, 32'hdeadbeef);
        eb_clr();
        for (int k = 0; k < 44; k++) eb[k] = msg[k];
        eb[44] = 8'h06; eb[71] = 8'h80;
        chk_blk("t1", 1'b1, 1'b1);
        hs();
        chk("t1_wait_busy", 64'(bus.busy), 64'd1);
        bus.op_valid = 1'b1; bus.cust5_op = OP_STORE; bus.cust5_limm = 6'd0;
        #1;
        chk("t1_wait_stall", 64'(bus.stall), 64'd1);
        bus.op_valid = 1'b0;
        give_dig(dig_vec);
        chk("t1_done_busy", 64'(bus.busy), 64'd0);
        op(OP_STORE, 6'd0, 32'h0);
        chk("t1_st0", 64'(bus.dataout), 64'h1e83d5b4);
        op(OP_STORE, 6'd15, 32'h0);
        chk("t1_st15", 64'(bus.dataout), 64'h2d92e4c3);

        // SHA3-512, exact fill: data block then all-pad block
        op(OP_HEAD, 6'b000011, 32'h0);
        for (int i = 0; i < 17; i++) op(OP_DATA, 6'd0, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        op(OP_TAIL, 6'd4, {8'd68, 8'd69, 8'd70, 8'd71});
        eb_clr();
        for (int k = 0; k < 72; k++) eb[k] = 8'(k);
        chk_blk("t2a", 1'b1, 1'b0);
        hs();
        eb_clr();
        eb[0] = 8'h06; eb[71] = 8'h80;
        chk_blk("t2b", 1'b0, 1'b1);
        hs();
        give_dig(dig_vec);

        // SHA3-512, 3-byte tail in last word: pad bytes coincide
        op(OP_HEAD, 6'b000011, 32'h0);
        for (int i = 0; i < 17; i++) op(OP_DATA, 6'd0, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        op(OP_TAIL, 6'd3, {8'd68, 8'd69, 8'd70, 8'hff});
        eb_clr();
        for (int k = 0; k < 71; k++) eb[k] = 8'(k);
        eb[71] = 8'h86;
        chk_blk("t3", 1'b1, 1'b1);
        hs();
        give_dig(dig_vec);

        // SHA3-256 with back-pressure on the first block
        op(OP_HEAD, 6'b000001, 32'h0);
        for (int i = 0; i < 34; i++) op(OP_DATA, 6'd0, 32'ha0000000 + 32'(i));
        eb_clr();
        for (int i = 0; i < 34; i++) eb_word(i, 32'ha0000000 + 32'(i));
        bus.op_valid = 1'b1; bus.cust5_op = OP_DATA; bus.operand_a = 32'hcafef00d;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4_stall%0d", c), 64'(bus.stall), 64'd1);
            cyc();
        end
        chk_blk("t4a", 1'b1, 1'b0);
        bus.blk_ready = 1'b1;
        #1;
        chk("t4_stall_hs", 64'(bus.stall), 64'd1);
        cyc();
        bus.blk_ready = 1'b0;
        #1;
        chk("t4_stall_rel", 64'(bus.stall), 64'd0);
        cyc();
        bus.op_valid = 1'b0;
        op(OP_TAIL, 6'd0, 32'h0);
        eb_clr();
        eb_word(0, 32'hcafef00d);
        eb[4] = 8'h06; eb[135] = 8'h80;
        chk_blk("t4b", 1'b0, 1'b1);
        hs();
        give_dig(dig_vec);
        op(OP_STORE, 6'd7, 32'h0);
        chk("t4_st7", 64'(bus.dataout), 64'h258adcbb);
        op(OP_STORE, 6'd8, 32'h0);
        chk("t4_st8", 64'(bus.dataout), 64'h0);

        // SHA3-224 empty message; digest truncated to 7 words
        op(OP_HEAD, 6'b000000, 32'h0);
        op(OP_TAIL, 6'd0, 32'h0);
        eb_clr();
        eb[0] = 8'h06; eb[143] = 8'h80;
        chk_blk("t5", 1'b1, 1'b1);
        hs();
        give_dig(dig_vec);
        op(OP_STORE, 6'd6, 32'h0);
        chk("t5_st6", 64'(bus.dataout), 64'h2489dbba);
        for (int i = 7; i < 16; i++) begin
            op(OP_STORE, 6'(i), 32'h0);
            chk($sformatf("t5_st%0d", i), 64'(bus.dataout), 64'h0);
        end
        give_dig(~dig_vec);
        op(OP_STORE, 6'd0, 32'h0);
        chk("t5_dig_ign", 64'(bus.dataout), 64'h1e83d5b4);

        // HEAD mid-absorb discards partial data
        op(OP_HEAD, 6'b000011, 32'h0);
        for (int i = 0; i < 3; i++) op(OP_DATA, 6'd0, 32'h11111111);
        op(OP_HEAD, 6'b000011, 32'h0);
        op(OP_DATA, 6'd0, 32'h600dcafe);
        op(OP_TAIL, 6'd0, 32'h0);
        eb_clr();
        eb_word(0, 32'h600dcafe);
        eb[4] = 8'h06; eb[71] = 8'h80;
        chk_blk("t6", 1'b1, 1'b1);
        hs();
        give_dig(dig_vec);
        op(OP_STORE, 6'd0, 32'h0);
        chk("t6_st0", 64'(bus.dataout), 64'h1e83d5b4);

        // Asynchronous reset while a block is offered
        op(OP_HEAD, 6'b000011, 32'h0);
        op(OP_TAIL, 6'd0, 32'h0);
        chk("t7_pre_vld", 64'(bus.blk_valid), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("t7_vld",   64'(bus.blk_valid), 64'd0);
        chk("t7_first", 64'(bus.blk_first), 64'd0);
        chk("t7_last",  64'(bus.blk_last),  64'd0);
        chk("t7_busy",  64'(bus.busy),      64'd0);
        chk("t7_dout",  64'(bus.dataout),   64'd0);
        chk("t7_blk",   64'(|bus.blk_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc();
        chk("t7_post_vld", 64'(bus.blk_valid), 64'd0);

`ifdef KECCAK_CTRL_ERR_EN
        chk("err_rst", 64'(err), 64'd0);
        op(OP_STORE, 6'd0, 32'h0);
        chk("err_store_idle", 64'(err), 64'd1);
        op(OP_HEAD, 6'b000011, 32'h0);
        chk("err_head_clr", 64'(err), 64'd0);
        op(5'b10000, 6'd0, 32'h0);
        chk("err_reserved", 64'(err), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
